// File: rtl/hazard_detection_unit_pkg.sv
// Shared definitions for the hazard detection unit: FSM encodings,
// output-mode selectors, the pipeline control bundle and a register-match helper.
package hazard_detection_unit_pkg;

  localparam int unsigned LU_W = 3;

  // Memory-wait FSM encodings
  localparam logic [1:0] HDU_RUN   = 2'd0;
  localparam logic [1:0] HDU_WAIT  = 2'd1;
  localparam logic [1:0] HDU_ERROR = 2'd2;

  // Output modes, listed lowest to highest priority
  localparam logic [1:0] MODE_RUN    = 2'd0;
  localparam logic [1:0] MODE_STALL  = 2'd1;
  localparam logic [1:0] MODE_FLUSH  = 2'd2;
  localparam logic [1:0] MODE_FREEZE = 2'd3;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;
  } hdu_ctrl_t;

  localparam hdu_ctrl_t CTRL_RUN = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                     id_ex_write: 1'b1, id_ex_flush: 1'b0, ex_mem_write: 1'b1};
  localparam hdu_ctrl_t CTRL_STALL = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                       id_ex_write: 1'b1, id_ex_flush: 1'b1, ex_mem_write: 1'b1};
  localparam hdu_ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                       id_ex_write: 1'b1, id_ex_flush: 1'b1, ex_mem_write: 1'b1};
  localparam hdu_ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                        id_ex_write: 1'b0, id_ex_flush: 1'b0, ex_mem_write: 1'b0};

  // True when the ID instruction actually reads register rs and it equals rd
  function automatic logic reads_reg(input logic use_rs, input logic [4:0] rs,
                                     input logic [4:0] rd);
    return use_rs && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_detection_unit_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
// Ports: clk, rst_n (async active-low), clr_i, en_i, cnt_o[W-1:0].
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear, else increment until all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_detection_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles,
// taken-branch flushes and data-memory wait freezes with a watchdog.
// Inputs : clk_i, rst_n_i, ID register reads (IF_ID_RS1/2_i, ID_use_rs1/2_i),
//          EX load info (ID_EX_RD_i, ID_EX_MemRead_i), EX_BranchTaken_i,
//          dmem_req_i / dmem_ack_i.
// Outputs: PC / IF_ID / ID_EX / EX_MEM write enables, IF_ID / ID_EX flushes
//          (combinational on current inputs and state), sticky mem_timeout_o,
//          saturating stall_cnt_o.
module hazard_detection_unit
  import hazard_detection_unit_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT       = 255,
  parameter int unsigned CNT_W             = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [4:0]       IF_ID_RS1_i,
  input  logic [4:0]       IF_ID_RS2_i,
  input  logic             ID_use_rs1_i,
  input  logic             ID_use_rs2_i,
  input  logic [4:0]       ID_EX_RD_i,
  input  logic             ID_EX_MemRead_i,
  input  logic             EX_BranchTaken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  output logic             PC_Write_o,
  output logic             IF_ID_Write_o,
  output logic             IF_ID_Flush_o,
  output logic             ID_EX_Write_o,
  output logic             ID_EX_Flush_o,
  output logic             EX_MEM_Write_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [LU_W-1:0] LU_RELOAD = LU_W'(LOAD_STALL_CYCLES - 1);

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [LU_W-1:0]   lu_cnt_q;
  logic [LU_W-1:0]   lu_cnt_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_stall_c;
  logic              load_use_c;
  logic [1:0]        mode_c;
  hdu_ctrl_t         ctrl_c;

  assign mem_stall_c = dmem_req_i & ~dmem_ack_i;

  // x0 is hardwired zero, so a load into it never creates a dependency
  assign load_use_c = ID_EX_MemRead_i && (ID_EX_RD_i != 5'd0) &&
                      (reads_reg(ID_use_rs1_i, IF_ID_RS1_i, ID_EX_RD_i) ||
                       reads_reg(ID_use_rs2_i, IF_ID_RS2_i, ID_EX_RD_i));

  // Priority mode select
  always_comb begin
    mode_c = MODE_RUN;
    if ((state_q == HDU_ERROR) || mem_stall_c) begin
      mode_c = MODE_FREEZE;
    end else if (EX_BranchTaken_i) begin
      mode_c = MODE_FLUSH;
    end else if (load_use_c || (lu_cnt_q != '0)) begin
      mode_c = MODE_STALL;
    end
  end

  // Pipeline controls and bubble counter; a freeze leaves lu_cnt untouched so
  // an interrupted load-use stall resumes once memory releases the pipe
  always_comb begin
    ctrl_c   = CTRL_RUN;
    lu_cnt_d = lu_cnt_q;
    case (mode_c)
      MODE_FREEZE: ctrl_c = CTRL_FREEZE;
      MODE_FLUSH: begin
        ctrl_c   = CTRL_FLUSH;
        lu_cnt_d = '0;
      end
      MODE_STALL: begin
        ctrl_c   = CTRL_STALL;
        lu_cnt_d = (lu_cnt_q == '0) ? LU_RELOAD : lu_cnt_q - LU_W'(1);
      end
      default: ;
    endcase
    if (!rst_n_i) begin
      ctrl_c = CTRL_FREEZE;
    end
  end

  // Memory-wait FSM; wait_cnt is already 1 on the first WAIT cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      HDU_RUN: begin
        if (mem_stall_c) state_d = HDU_WAIT;
      end
      HDU_WAIT: begin
        if (!mem_stall_c) begin
          state_d = HDU_RUN;
        end else if ((MEM_TIMEOUT != 0) && (wait_cnt == WAIT_W'(MEM_TIMEOUT))) begin
          state_d = HDU_ERROR;
        end
      end
      HDU_ERROR: state_d = HDU_ERROR;
      default:   state_d = HDU_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= HDU_RUN;
      lu_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  // Consecutive dmem wait cycles
  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .clr_i (~mem_stall_c),
    .en_i  (mem_stall_c & (state_q != HDU_ERROR)),
    .cnt_o (wait_cnt)
  );

  // Performance counter of cycles where the PC did not advance
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .clr_i (1'b0),
    .en_i  (~ctrl_c.pc_write),
    .cnt_o (stall_cnt_o)
  );

  assign PC_Write_o     = ctrl_c.pc_write;
  assign IF_ID_Write_o  = ctrl_c.if_id_write;
  assign IF_ID_Flush_o  = ctrl_c.if_id_flush;
  assign ID_EX_Write_o  = ctrl_c.id_ex_write;
  assign ID_EX_Flush_o  = ctrl_c.id_ex_flush;
  assign EX_MEM_Write_o = ctrl_c.ex_mem_write;
  assign mem_timeout_o  = (state_q == HDU_ERROR);

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Bench for hazard_detection_unit: two instances share stimulus
// (inst0: 3 bubbles, timeout 8, 4-bit counter; inst1: defaults).
module tb_hazard_detection_unit;

  // Expected control vectors {PC_W, IFID_W, IFID_F, IDEX_W, IDEX_F, EXMEM_W, timeout}
  localparam logic [6:0] C_RUN    = 7'b1101010;
  localparam logic [6:0] C_FLUSH  = 7'b1111110;
  localparam logic [6:0] C_STALL  = 7'b0001110;
  localparam logic [6:0] C_FREEZE = 7'b0000000;
  localparam logic [6:0] C_ERR    = 7'b0000001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic use1 = 1'b0, use2 = 1'b0, memrd = 1'b0, br = 1'b0, req = 1'b0, ack = 1'b0;

  logic pc0, ifw0, iff0, idw0, idf0, exw0, to0;
  logic [3:0] cnt0;
  logic pc1, ifw1, iff1, idw1, idf1, exw1, to1;
  logic [31:0] cnt1;

  logic [6:0]  obs_ctl [2];
  logic [31:0] obs_cnt [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_detection_unit #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(8), .CNT_W(4)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .IF_ID_RS1_i(rs1), .IF_ID_RS2_i(rs2),
    .ID_use_rs1_i(use1), .ID_use_rs2_i(use2), .ID_EX_RD_i(rd), .ID_EX_MemRead_i(memrd),
    .EX_BranchTaken_i(br), .dmem_req_i(req), .dmem_ack_i(ack),
    .PC_Write_o(pc0), .IF_ID_Write_o(ifw0), .IF_ID_Flush_o(iff0), .ID_EX_Write_o(idw0),
    .ID_EX_Flush_o(idf0), .EX_MEM_Write_o(exw0), .mem_timeout_o(to0), .stall_cnt_o(cnt0)
  );

  hazard_detection_unit dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .IF_ID_RS1_i(rs1), .IF_ID_RS2_i(rs2),
    .ID_use_rs1_i(use1), .ID_use_rs2_i(use2), .ID_EX_RD_i(rd), .ID_EX_MemRead_i(memrd),
    .EX_BranchTaken_i(br), .dmem_req_i(req), .dmem_ack_i(ack),
    .PC_Write_o(pc1), .IF_ID_Write_o(ifw1), .IF_ID_Flush_o(iff1), .ID_EX_Write_o(idw1),
    .ID_EX_Flush_o(idf1), .EX_MEM_Write_o(exw1), .mem_timeout_o(to1), .stall_cnt_o(cnt1)
  );

  assign obs_ctl[0] = {pc0, ifw0, iff0, idw0, idf0, exw0, to0};
  assign obs_ctl[1] = {pc1, ifw1, iff1, idw1, idf1, exw1, to1};
  assign obs_cnt[0] = {28'd0, cnt0};
  assign obs_cnt[1] = cnt1;

  // Reference model: bubbles owed, consecutive wait length, sticky error, stall total
  int unsigned     p_lsc [2] = '{3, 1};
  int unsigned     p_mt  [2] = '{8, 255};
  longint unsigned p_max [2] = '{64'd15, 64'hFFFF_FFFF};

  int unsigned     m_left [2] = '{0, 0};
  int unsigned     m_wait [2] = '{0, 0};
  bit              m_err  [2] = '{1'b0, 1'b0};
  longint unsigned m_cnt  [2] = '{64'd0, 64'd0};
  int unsigned     n_left [2];
  int unsigned     n_wait [2];
  bit              n_err  [2];
  longint unsigned n_cnt  [2];
  logic [6:0]      exp_ctl [2];
  logic [31:0]     exp_cnt [2];
  bit lu, ms;

  always_comb begin
    lu = memrd && (rd != 5'd0) && ((use1 && rd == rs1) || (use2 && rd == rs2));
    ms = req && !ack;
    for (int k = 0; k < 2; k++) begin
      n_left[k] = m_left[k];
      n_err[k]  = m_err[k];
      n_wait[k] = ms ? m_wait[k] + 32'd1 : 32'd0;
      if (m_err[k] || ms) begin
        exp_ctl[k] = m_err[k] ? C_ERR : C_FREEZE;
        if (ms && p_mt[k] != 0 && m_wait[k] + 32'd1 > p_mt[k]) n_err[k] = 1'b1;
      end else if (br) begin
        exp_ctl[k] = C_FLUSH;
        n_left[k]  = 0;
      end else if (lu || m_left[k] != 0) begin
        exp_ctl[k] = C_STALL;
        n_left[k]  = (m_left[k] != 0) ? m_left[k] - 32'd1 : p_lsc[k] - 32'd1;
      end else begin
        exp_ctl[k] = C_RUN;
      end
      n_cnt[k] = m_cnt[k];
      if (!exp_ctl[k][6] && m_cnt[k] < p_max[k]) n_cnt[k] = m_cnt[k] + 64'd1;
      if (!rst_n) exp_ctl[k] = C_FREEZE;
      exp_cnt[k] = 32'(m_cnt[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_left[k] <= 0;
        m_wait[k] <= 0;
        m_err[k]  <= 1'b0;
        m_cnt[k]  <= 64'd0;
      end else begin
        m_left[k] <= n_left[k];
        m_wait[k] <= n_wait[k];
        m_err[k]  <= n_err[k];
        m_cnt[k]  <= n_cnt[k];
      end
    end
  end

  task automatic idle();
    rs1 = '0; rs2 = '0; rd = '0;
    use1 = 1'b0; use2 = 1'b0; memrd = 1'b0; br = 1'b0; req = 1'b0; ack = 1'b0;
  endtask

  task automatic set_load_use();
    memrd = 1'b1; rd = 5'd5; rs1 = 5'd5; rs2 = 5'd1; use1 = 1'b1; use2 = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_load_use();
    br = 1'b1; req = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (obs_ctl[k] !== C_FREEZE || obs_cnt[k] !== 32'd0 || obs_ctl[k] !== exp_ctl[k]) begin
        n_fail++;
        $display("FAIL reset_hold i%0d: ctl=%b cnt=%0d, want ctl=%b cnt=0", k, obs_ctl[k], obs_cnt[k], C_FREEZE);
      end
    end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (obs_ctl[k] !== C_RUN || obs_cnt[k] !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_release i%0d: ctl=%b cnt=%0d, want ctl=%b cnt=0", k, obs_ctl[k], obs_cnt[k], C_RUN);
      end
    end
  endtask

  task automatic test_load_use();
    int st0;
    st0 = 0;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      idle();
      if (c == 0) set_load_use();
      #1;
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (obs_ctl[k] !== exp_ctl[k] || obs_cnt[k] !== exp_cnt[k]) begin
          n_fail++;
          $display("FAIL load_use i%0d c%0d: ctl=%b cnt=%0d, want ctl=%b cnt=%0d", k, c, obs_ctl[k], obs_cnt[k], exp_ctl[k], exp_cnt[k]);
        end
      end
      if (obs_ctl[0] === C_STALL) st0++;
      if (c == 1) begin
        n_tests++;
        if (obs_ctl[1] !== C_RUN || obs_cnt[1] !== 32'd1) begin
          n_fail++;
          $display("FAIL load_use_single: ctl=%b cnt=%0d, want ctl=%b cnt=1", obs_ctl[1], obs_cnt[1], C_RUN);
        end
      end
    end
    n_tests++;
    if (st0 != 3 || obs_cnt[0] !== 32'd3) begin
      n_fail++;
      $display("FAIL load_use_three: stalls=%0d cnt=%0d, want 3 and 3", st0, obs_cnt[0]);
    end
  endtask

  task automatic test_rd_zero();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      idle();
      case (c)
        0: begin memrd = 1'b1; use1 = 1'b1; use2 = 1'b1; end
        1: begin memrd = 1'b1; rd = 5'd7; rs1 = 5'd7; rs2 = 5'd3; use2 = 1'b1; end
        2: begin memrd = 1'b1; rd = 5'd7; rs2 = 5'd7; use2 = 1'b1; end
        3: begin rd = 5'd7; rs1 = 5'd7; use1 = 1'b1; end
        default: ;
      endcase
      #1;
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (obs_ctl[k] !== exp_ctl[k] || obs_cnt[k] !== exp_cnt[k]) begin
          n_fail++;
          $display("FAIL rd_zero i%0d c%0d: ctl=%b cnt=%0d, want ctl=%b cnt=%0d", k, c, obs_ctl[k], obs_cnt[k], exp_ctl[k], exp_cnt[k]);
        end
        if (c < 3) begin
          n_tests++;
          if (obs_ctl[k] !== ((c == 2) ? C_STALL : C_RUN)) begin
            n_fail++;
            $display("FAIL rd_zero_fixed i%0d c%0d: ctl=%b, want %b", k, c, obs_ctl[k], (c == 2) ? C_STALL : C_RUN);
          end
        end
      end
    end
  endtask

  task automatic test_branch();
    logic [6:0] want;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      idle();
      if (c == 0 || c == 2) set_load_use();
      if (c == 0 || c == 3) br = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (obs_ctl[k] !== exp_ctl[k] || obs_cnt[k] !== exp_cnt[k]) begin
          n_fail++;
          $display("FAIL branch i%0d c%0d: ctl=%b cnt=%0d, want ctl=%b cnt=%0d", k, c, obs_ctl[k], obs_cnt[k], exp_ctl[k], exp_cnt[k]);
        end
      end
      want = (c == 0 || c == 3) ? C_FLUSH : (c == 2) ? C_STALL : C_RUN;
      n_tests++;
      if (obs_ctl[0] !== want) begin
        n_fail++;
        $display("FAIL branch_fixed c%0d: ctl=%b, want %b", c, obs_ctl[0], want);
      end
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      idle();
      req = (c < 6);
      ack = (c == 0 || c == 5);
      if (c == 2) begin set_load_use(); br = 1'b1; end
      #1;
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (obs_ctl[k] !== exp_ctl[k] || obs_cnt[k] !== exp_cnt[k]) begin
          n_fail++;
          $display("FAIL mem_wait i%0d c%0d: ctl=%b cnt=%0d, want ctl=%b cnt=%0d", k, c, obs_ctl[k], obs_cnt[k], exp_ctl[k], exp_cnt[k]);
        end
        n_tests++;
        if (obs_ctl[k] !== ((c >= 1 && c <= 4) ? C_FREEZE : C_RUN)) begin
          n_fail++;
          $display("FAIL mem_wait_fixed i%0d c%0d: ctl=%b", k, c, obs_ctl[k]);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (obs_cnt[k] !== 32'd4) begin
        n_fail++;
        $display("FAIL mem_wait_cnt i%0d: cnt=%0d, want 4", k, obs_cnt[k]);
      end
    end
    // Reset in the middle of a wait
    repeat (2) begin
      @(negedge clk);
      req = 1'b1; ack = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (obs_ctl[k] !== C_RUN || obs_cnt[k] !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_mid_wait i%0d: ctl=%b cnt=%0d, want ctl=%b cnt=0", k, obs_ctl[k], obs_cnt[k], C_RUN);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      idle();
      req = (c < 20);
      if (c == 22) begin set_load_use(); br = 1'b1; end
      #1;
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (obs_ctl[k] !== exp_ctl[k] || obs_cnt[k] !== exp_cnt[k]) begin
          n_fail++;
          $display("FAIL timeout i%0d c%0d: ctl=%b cnt=%0d, want ctl=%b cnt=%0d", k, c, obs_ctl[k], obs_cnt[k], exp_ctl[k], exp_cnt[k]);
        end
      end
      if (c == 8 || c == 9 || c == 21) begin
        n_tests++;
        if (obs_ctl[0] !== ((c == 8) ? C_FREEZE : C_ERR)) begin
          n_fail++;
          $display("FAIL timeout_edge c%0d: ctl=%b, want %b", c, obs_ctl[0], (c == 8) ? C_FREEZE : C_ERR);
        end
      end
    end
    n_tests++;
    if (obs_cnt[0] !== 32'd15 || obs_cnt[1] !== 32'd20 || obs_ctl[1] !== C_RUN) begin
      n_fail++;
      $display("FAIL saturate: cnt0=%0d cnt1=%0d ctl1=%b, want 15 20 %b", obs_cnt[0], obs_cnt[1], obs_ctl[1], C_RUN);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (obs_ctl[0] !== C_RUN || obs_cnt[0] !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_from_error: ctl=%b cnt=%0d, want ctl=%b cnt=0", obs_ctl[0], obs_cnt[0], C_RUN);
    end
  endtask

  task automatic test_stall_during_bubbles();
    int st0;
    st0 = 0;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      idle();
      if (c == 0) set_load_use();
      req = (c >= 1 && c <= 3);
      ack = (c == 3);
      #1;
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (obs_ctl[k] !== exp_ctl[k] || obs_cnt[k] !== exp_cnt[k]) begin
          n_fail++;
          $display("FAIL bubble_freeze i%0d c%0d: ctl=%b cnt=%0d, want ctl=%b cnt=%0d", k, c, obs_ctl[k], obs_cnt[k], exp_ctl[k], exp_cnt[k]);
        end
      end
      if (obs_ctl[0] === C_STALL) st0++;
      if (c == 3) begin
        n_tests++;
        if (obs_ctl[0] !== C_STALL || obs_ctl[1] !== C_RUN) begin
          n_fail++;
          $display("FAIL bubble_resume: ctl0=%b ctl1=%b, want %b %b", obs_ctl[0], obs_ctl[1], C_STALL, C_RUN);
        end
      end
    end
    n_tests++;
    if (st0 != 3 || obs_cnt[0] !== 32'd5) begin
      n_fail++;
      $display("FAIL bubble_total: stalls=%0d cnt=%0d, want 3 and 5", st0, obs_cnt[0]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 99) != 0);
      rs1   = 5'($urandom_range(0, 3));
      rs2   = 5'($urandom_range(0, 3));
      rd    = 5'($urandom_range(0, 3));
      use1  = 1'($urandom_range(0, 1));
      use2  = 1'($urandom_range(0, 1));
      memrd = 1'($urandom_range(0, 1));
      br    = ($urandom_range(0, 7) == 0);
      req   = ($urandom_range(0, 3) == 0);
      ack   = 1'($urandom_range(0, 1));
      #1;
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (obs_ctl[k] !== exp_ctl[k] || obs_cnt[k] !== exp_cnt[k]) begin
          n_fail++;
          $display("FAIL random i%0d c%0d: ctl=%b cnt=%0d, want ctl=%b cnt=%0d", k, c, obs_ctl[k], obs_cnt[k], exp_ctl[k], exp_cnt[k]);
        end
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_rd_zero();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_stall_during_bubbles();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
